reg_access_arb: RTL
===================

Name: reg_access_arb

Overview:
- Owns every access port of the 12x8 register file: read enable/addresses, write port, carry-write port.
- Arbitrates single-beat read/write requests from two requesters. Port 0 is the core sequencer; port 1 is the debug/loader.
- Round-robin fairness between the two ports; the ALU carry write always has priority on the carry register.
- After reset, runs an init sequence that zeroes r1..r(NUM_REGS-1), because the register array has no reset.

Parameters:
NUM_REGS, 12, number of registers in the file
REG_WIDTH, 8, data width
CAR_REG, 11, index of the carry register
AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  2  per-port request valid
req_ready  out  2  per-port accept; transfer when valid&ready
req_write  in  2  per-port: 1=write, 0=read
req_addr  in  2xAW  per-port register address
req_wdata  in  2xREG_WIDTH  per-port write data
rsp_valid  out  2  per-port read response valid
rsp_data  out  REG_WIDTH  read data; meaningful only with a rsp_valid bit set
car_valid  in  1  ALU carry write request (never stalled)
car_data  in  REG_WIDTH  carry value
init_done  out  1  high once init completes
rf_reg_read  out  1  register file read enable
rf_rs_addr  out  AW  read address
rf_rt_addr  out  AW  second read address; driven equal to rf_rs_addr
rf_reg_write  out  1  register file write enable
rf_rd_addr  out  AW  write address
rf_rd_in  out  REG_WIDTH  write data
rf_car_write  out  1  carry write enable
rf_car_in  out  REG_WIDTH  carry data
rf_rs_out  in  REG_WIDTH  registered read data from the register file

Behaviour:
- Reset (async, any cycle, including mid-init or with a read in flight):
  - state=INIT, init counter=1, rr pointer=0.
  - rsp_valid=0, init_done=0, req_ready=0.
  - Any pending response is dropped.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle drives rf_reg_write=1, rf_rd_addr=counter, rf_rd_in=0; counter increments.
  - After writing NUM_REGS-1, state goes to RUN on the next edge. INIT therefore lasts NUM_REGS-1 cycles (11 by default).
  - req_ready=0 throughout INIT.
- RUN: init_done=1. There is no return to INIT except via rst.
- Carry path:
  - rf_car_write=car_valid and rf_car_in=car_data, combinationally, in every state.
  - During INIT, a carry write to CAR_REG in the same cycle as the init write wins in the register file. Accept that outcome; do not stall init.
- Eligibility in RUN:
  - A port is eligible when req_valid is set.
  - Exception: a port is ineligible when it requests a write to CAR_REG while car_valid=1.
- Grant:
  - At most one grant per cycle. req_ready is combinational and set only for the granted port.
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port equal to rr is granted.
  - On every accepted transfer, rr <= ~granted port.
- Accepted write:
  - Same cycle, drive rf_reg_write=1, rf_rd_addr=req_addr, rf_rd_in=req_wdata. The write takes effect at that edge.
  - A write to r0 is accepted and completes the handshake; the register file discards it.
- Accepted read:
  - Same cycle, drive rf_reg_read=1 and rf_rs_addr=rf_rt_addr=req_addr.
  - On the next cycle rsp_valid[p]=1 (registered, exactly 1-cycle latency) and rsp_data=rf_rs_out.
  - A new grant may be made in the response cycle, giving back-to-back throughput of 1 per cycle.
- Ordering: a read granted in the cycle after a write to the same address returns the new value. No same-cycle read/write hazard exists, since there is one grant per cycle.
- Defaults when idle: rf_reg_read=0, rf_reg_write=0; addresses and data are held at 0.
- Out-of-range addresses (>=NUM_REGS) are accepted as normal transfers. Results are undefined in the register file and are not checked.

Decomposition:
- Package reg_arb_pkg holds:
  - state enum (INIT, RUN)
  - port-index typedef (PORT_CORE=0, PORT_DBG=1)
  - address and data typedefs derived from NUM_REGS and REG_WIDTH
- Sub-module rr_arb2: 2-way round-robin arbiter with eligible-in, grant-out and an advance strobe. The rest of the block stays in reg_access_arb.

Test Plan:
- Reset then idle -> writes of 0 to addrs 1..11 on 11 consecutive cycles. init_done rises on cycle 12. req_ready=0 before that.
- RUN, port0 writes r3=0x5A; next cycle port1 reads r3 -> rsp_valid[1] one cycle after accept, rsp_data=0x5A.
- Both ports hold valid reads for 4 cycles from rr=0 -> grants alternate 0,1,0,1; each rsp_valid is 1 cycle after its grant.
- Port0 writes r11=0x01 while car_valid=1 with car_data=0xFF -> port0 stalled; port1 may be granted. Next cycle with car_valid=0, port0 accepted; a later read of r11 returns 0x01.
- Port1 writes r0=0x77 -> accepted; a read of r0 returns 0x00.
- rst asserted in the cycle after a read accept -> rsp_valid stays 0, init restarts at addr 1, init_done=0.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
// The FSM encodings are plain constants so older code can still compare against them.
package reg_arb_pkg;

  localparam int NUM_REGS  = 12;
  localparam int REG_WIDTH = 8;
  localparam int CAR_REG   = 11;
  localparam int AW        = $clog2(NUM_REGS);

  typedef logic [0:0] state_t;
  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

  typedef logic [AW-1:0]        addr_t;
  typedef logic [REG_WIDTH-1:0] data_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. When both requesters are eligible, the port named
// by the pointer wins. The pointer moves past the winner on each advance strobe.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  input  logic       advance,
  output logic [1:0] grant
);

  port_e rr_r;

  // one-hot grant: a lone eligible port wins outright, a tie goes to the pointer
  always_comb begin
    grant = 2'b00;
    if (elig == 2'b11) begin
      if (rr_r == PORT_DBG) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else begin
      grant = elig;
    end
  end

  // pointer update on an accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r <= PORT_CORE;
    end else if (advance) begin
      rr_r <= port_e'(~grant[1]);
    end else begin
      rr_r <= rr_r;
    end
  end

endmodule

// File: rtl/reg_access_arb.sv
// Sole owner of the register file ports: clears r1..rN-1 after reset, then arbitrates
// single-beat reads and writes from the core and debug ports, next to the ALU carry write.
module reg_access_arb
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REGS  = 12,
  parameter  int REG_WIDTH = 8,
  parameter  int CAR_REG   = 11,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_write,
  input  logic [1:0][AW-1:0]        req_addr,
  input  logic [1:0][REG_WIDTH-1:0] req_wdata,
  output logic [1:0]                rsp_valid,
  output logic [REG_WIDTH-1:0]      rsp_data,
  input  logic                      car_valid,
  input  logic [REG_WIDTH-1:0]      car_data,
  output logic                      init_done,
  output logic                      rf_reg_read,
  output logic [AW-1:0]             rf_rs_addr,
  output logic [AW-1:0]             rf_rt_addr,
  output logic                      rf_reg_write,
  output logic [AW-1:0]             rf_rd_addr,
  output logic [REG_WIDTH-1:0]      rf_rd_in,
  output logic                      rf_car_write,
  output logic [REG_WIDTH-1:0]      rf_car_in,
  input  logic [REG_WIDTH-1:0]      rf_rs_out
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] CAR_ADDR  = AW'(CAR_REG);

  state_t        state_r;
  logic [AW-1:0] cnt_r;
  logic [1:0]    rsp_valid_r;
  logic [1:0]    elig_s;
  logic [1:0]    grant_s;
  logic          gnt_port_s;

  // a port that would race the ALU carry write on the carry register sits out this cycle
  always_comb begin
    elig_s = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if ((state_r == ST_RUN) && req_valid[p] &&
          !(req_write[p] && (req_addr[p] == CAR_ADDR) && car_valid)) begin
        elig_s[p] = 1'b1;
      end else begin
        elig_s[p] = 1'b0;
      end
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .elig    (elig_s),
    .advance (grant_s != 2'b00),
    .grant   (grant_s)
  );

  assign gnt_port_s = grant_s[1];
  assign req_ready  = grant_s;
  assign init_done  = (state_r == ST_RUN);
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rf_rs_out;

  // carry writes bypass arbitration entirely, even during init
  assign rf_car_write = car_valid;
  assign rf_car_in    = car_data;

  // register file port mux: the init clear sweep, or the single granted transfer
  always_comb begin
    rf_reg_read  = 1'b0;
    rf_rs_addr   = {AW{1'b0}};
    rf_reg_write = 1'b0;
    rf_rd_addr   = {AW{1'b0}};
    rf_rd_in     = {REG_WIDTH{1'b0}};
    if (state_r == ST_INIT) begin
      rf_reg_write = 1'b1;
      rf_rd_addr   = cnt_r;
    end else if (grant_s != 2'b00) begin
      if (req_write[gnt_port_s]) begin
        rf_reg_write = 1'b1;
        rf_rd_addr   = req_addr[gnt_port_s];
        rf_rd_in     = req_wdata[gnt_port_s];
      end else begin
        rf_reg_read = 1'b1;
        rf_rs_addr  = req_addr[gnt_port_s];
      end
    end else begin
      rf_reg_read  = 1'b0;
      rf_reg_write = 1'b0;
    end
  end

  assign rf_rt_addr = rf_rs_addr;

  // init sweep counter and FSM; RUN is left only through rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
      cnt_r   <= AW'(1);
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + AW'(1);
          if (cnt_r == LAST_ADDR) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          cnt_r   <= cnt_r;
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= AW'(1);
        end
      endcase
    end
  end

  // read response flag follows the register file's one-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 2'b00;
    end else begin
      rsp_valid_r <= grant_s & ~req_write;
    end
  end

endmodule
